// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared definitions for the SAR analog-front-end responder.
//               Holds the checker-state encoding, the dither LFSR seed and
//               feedback mask, the LFSR-to-dither mapping and the default
//               sample width.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    // Default sample / DAC code width.
    localparam int c_DEFAULT_DATA = 8;

    // Dither LFSR: seed value and right-shifting Galois feedback mask for
    // x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

    // Result checker state.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chk_state_t;

    // Dither offset applied to the held sample before comparison.
    typedef enum logic [1:0] {
        DITH_DEC  = 2'd0,
        DITH_NONE = 2'd1,
        DITH_INC  = 2'd2
    } dither_t;

    // LFSR[1:0]: 00 -> -1, 01/10 -> 0, 11 -> +1.
    function automatic dither_t dither_map(input logic [1:0] sel);
        dither_t d;
        case (sel)
            2'b00:   d = DITH_DEC;
            2'b11:   d = DITH_INC;
            default: d = DITH_NONE;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sar_sample_fifo
// Description : Synchronous sample FIFO. Pushes are dropped when full, pops
//               are ignored when empty; a push and a pop in the same cycle
//               both take effect. Read data is the current head entry.
// Ports       : clk, rst (async, active-high)
//               i_push/i_data   - write request and data
//               i_pop           - read request (head advances)
//               o_data          - head entry
//               o_full/o_empty  - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sar_sample_fifo #(
    parameter int DATA  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [DATA-1:0] i_data,
    input  logic            i_pop,
    output logic [DATA-1:0] o_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [DATA-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sar_afe_model.sv
`default_nettype none
// ============================================================================
// Module      : sar_afe_model
// Description : Analog-front-end responder for the SAR conversion controller.
//               Buffers incoming samples, acts as the sample-and-hold,
//               answers the controller's (active-low) DAC code with a
//               comparator decision and checks each conversion result
//               against the sample that was held while it ran.
// Ports       : Clock, Reset (async, active-high)
//               SampleIn/SampleValid/SampleReady - sample stream in
//               SAROut  - active-low DAC drive from the controller
//               Ready   - conversion-done strobe (acquire event)
//               DataOut - conversion result from the controller
//               Compare - comparator decision (combinational)
//               Held    - current held sample
//               Underrun- one-cycle pulse, acquire found the FIFO empty
//               Match   - last check within TOL
//               ErrCount- saturating count of failed checks
// Config      : SAR_AFE_DITHER_EN - adds an LFSR driven +/-1 LSB dither on
//               the comparator input (checker still uses undithered Held).
// Revision    : 1.0 - initial release
// ============================================================================
module sar_afe_model
    import sar_pkg::*;
#(
    parameter int DATA  = c_DEFAULT_DATA,
    parameter int DEPTH = 4,
    parameter int TOL   = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [DATA-1:0] SampleIn,
    input  logic            SampleValid,
    output logic            SampleReady,
    input  logic [DATA-1:0] SAROut,
    input  logic            Ready,
    input  logic [DATA-1:0] DataOut,
    output logic            Compare,
    output logic [DATA-1:0] Held,
    output logic            Underrun,
    output logic            Match,
    output logic [7:0]      ErrCount
);

    localparam logic [DATA:0] c_TOL = (DATA+1)'(TOL);

    chk_state_t      r_state;
    logic [DATA-1:0] r_held;
    logic            r_underrun;
    logic            r_match;
    logic [7:0]      r_err;

    logic [DATA-1:0] w_fifo_data;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [DATA:0]   w_dout_x;
    logic [DATA:0]   w_held_x;
    logic [DATA:0]   w_mag;
    logic            w_within;
    logic [DATA-1:0] w_held_eff;

    // ------------------------------------------------------------------
    // Sample FIFO: the acquire strobe doubles as the pop request.
    // ------------------------------------------------------------------
    sar_sample_fifo #(
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .i_push  (SampleValid),
        .i_data  (SampleIn),
        .i_pop   (Ready),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign SampleReady = ~w_fifo_full;

    // ------------------------------------------------------------------
    // Result check: unsigned magnitude of DataOut - Held in DATA+1 bits.
    // Held here is the value before this edge's reload.
    // ------------------------------------------------------------------
    assign w_dout_x = {1'b0, DataOut};
    assign w_held_x = {1'b0, r_held};
    assign w_mag    = (w_dout_x >= w_held_x) ? (w_dout_x - w_held_x)
                                             : (w_held_x - w_dout_x);
    assign w_within = (w_mag <= c_TOL);

    // ------------------------------------------------------------------
    // Checker FSM, sample-and-hold and status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_held     <= '0;
            r_underrun <= 1'b0;
            r_match    <= 1'b1;
            r_err      <= 8'd0;
        end else begin
            r_underrun <= Ready & w_fifo_empty;
            if (Ready) begin
                if (!w_fifo_empty) begin
                    r_held <= w_fifo_data;
                end
                case (r_state)
                    // First acquire only loads the hold; nothing to check yet.
                    IDLE: begin
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        r_match <= w_within;
                        if (!w_within && (r_err != 8'hFF)) begin
                            r_err <= r_err + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Held     = r_held;
    assign Underrun = r_underrun;
    assign Match    = r_match;
    assign ErrCount = r_err;

    // ------------------------------------------------------------------
    // Optional comparator dither.
    // ------------------------------------------------------------------
`ifdef SAR_AFE_DITHER_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 8'h00);
        end
    end

    // Offset saturates at both code limits rather than wrapping.
    always_comb begin
        w_held_eff = r_held;
        case (dither_map(r_lfsr[1:0]))
            DITH_DEC: begin
                if (r_held != '0) begin
                    w_held_eff = r_held - DATA'(1);
                end
            end
            DITH_INC: begin
                if (r_held != '1) begin
                    w_held_eff = r_held + DATA'(1);
                end
            end
            default: begin
                w_held_eff = r_held;
            end
        endcase
    end
`else
    assign w_held_eff = r_held;
`endif

    // Zero-latency comparator: the controller samples it in the same cycle
    // its DAC code changes. Ties keep the bit.
    assign Compare = (r_state == ARMED) && (w_held_eff >= ~SAROut);

endmodule
`default_nettype wire

// File: tb/tb_sar_afe_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_afe_model
// Description : Self-checking bench for sar_afe_model. Acquire-edge results
//               are queued as expected records and checked by a monitor
//               process; static outputs are checked in-line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_afe_model;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] SampleIn = 8'h00;
    logic       SampleValid = 1'b0;
    logic       SampleReady;
    logic [7:0] SAROut = 8'hFF;
    logic       Ready = 1'b0;
    logic [7:0] DataOut = 8'h00;
    logic       Compare;
    logic [7:0] Held;
    logic       Underrun;
    logic       Match;
    logic [7:0] ErrCount;

    typedef struct {
        logic       und;
        logic       mat;
        logic [7:0] err;
        logic [7:0] held;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic acq_seen;

    sar_afe_model #(
        .DATA  (8),
        .DEPTH (4),
        .TOL   (1)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SampleIn    (SampleIn),
        .SampleValid (SampleValid),
        .SampleReady (SampleReady),
        .SAROut      (SAROut),
        .Ready       (Ready),
        .DataOut     (DataOut),
        .Compare     (Compare),
        .Held        (Held),
        .Underrun    (Underrun),
        .Match       (Match),
        .ErrCount    (ErrCount)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Marks edges where the DUT took an acquire event.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) acq_seen <= 1'b0;
        else       acq_seen <= Ready;
    end

    // Monitor: one expected record per acquire edge.
    always @(negedge Clock) begin
        if (acq_seen) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acq_underrun", int'(Underrun), int'(e.und));
                chk("acq_match",    int'(Match),    int'(e.mat));
                chk("acq_errcount", int'(ErrCount), int'(e.err));
                chk("acq_held",     int'(Held),     int'(e.held));
            end
        end
    end

    task automatic push(input logic [7:0] s);
        @(negedge Clock);
        SampleIn    = s;
        SampleValid = 1'b1;
        @(negedge Clock);
        SampleValid = 1'b0;
    endtask

    task automatic acquire(input logic [7:0] dout, input logic und,
                           input logic mat, input logic [7:0] err,
                           input logic [7:0] held);
        exp_t e;
        @(negedge Clock);
        DataOut = dout;
        Ready   = 1'b1;
        e.und = und; e.mat = mat; e.err = err; e.held = held;
        exp_q.push_back(e);
        @(negedge Clock);
        Ready = 1'b0;
    endtask

    task automatic compare_at(input string name, input logic [7:0] code,
                              input logic exp);
        SAROut = ~code;
        #1;
        chk(name, int'(Compare), int'(exp));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sready"},   int'(SampleReady), 1);
        chk({tag, "_compare"},  int'(Compare),     0);
        chk({tag, "_held"},     int'(Held),        0);
        chk({tag, "_underrun"}, int'(Underrun),    0);
        chk({tag, "_match"},    int'(Match),       1);
        chk({tag, "_errcount"}, int'(ErrCount),    0);
    endtask

    // Bench-side SAR controller: MSB-first binary search on Compare.
    task automatic convert(output logic [7:0] res);
        logic [7:0] code;
        logic [7:0] trial;
        code = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            @(negedge Clock);
            trial  = code | (8'h01 << b);
            SAROut = ~trial;
            #1;
            if (Compare) code = trial;
        end
        SAROut = 8'hFF;
        res = code;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] samples [4];
        logic [7:0] res;
        int         e;

        samples[0] = 8'h00; samples[1] = 8'h7F;
        samples[2] = 8'hFF; samples[3] = 8'h81;

        // Reset state, including Compare forced low in IDLE.
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_vals("reset");
        compare_at("idle_compare_forced", 8'h00, 1'b0);

        // First acquire loads Held, no check.
        push(8'h5A);
        acquire(8'h00, 1'b0, 1'b1, 8'd0, 8'h5A);
        @(negedge Clock);
        compare_at("cmp_5A_vs_40", 8'h40, 1'b1);
        compare_at("cmp_5A_vs_80", 8'h80, 1'b0);
        compare_at("cmp_5A_tie",   8'h5A, 1'b1);
        compare_at("cmp_5A_vs_5B", 8'h5B, 1'b0);
        SAROut = 8'hFF;

        // Within tolerance, Held reloads.
        push(8'h10);
        acquire(8'h5B, 1'b0, 1'b1, 8'd0, 8'h10);

        // Mismatch on empty FIFO: underrun, Held unchanged.
        acquire(8'h20, 1'b1, 1'b0, 8'd1, 8'h10);
        @(negedge Clock);
        chk("underrun_one_cycle", int'(Underrun), 0);
        chk("held_after_underrun", int'(Held), 8'h10);

        // ErrCount saturation.
        for (int i = 0; i < 299; i++) begin
            e = (i + 2 > 255) ? 255 : i + 2;
            acquire(8'h20, 1'b1, 1'b0, 8'(e), 8'h10);
        end

        // Fill FIFO, refused fifth push.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("full_sready", int'(SampleReady), 0);
        push(8'h99);
        chk("full_sready_after_5th", int'(SampleReady), 0);
        acquire(8'h10, 1'b0, 1'b1, 8'd255, 8'h01);
        chk("sready_after_pop", int'(SampleReady), 1);
        acquire(8'h01, 1'b0, 1'b1, 8'd255, 8'h02);
        acquire(8'h02, 1'b0, 1'b1, 8'd255, 8'h03);
        acquire(8'h03, 1'b0, 1'b1, 8'd255, 8'h04);
        acquire(8'h04, 1'b1, 1'b1, 8'd255, 8'h04);

        // Same-cycle push and pop on an empty FIFO: underrun, sample kept.
        @(negedge Clock);
        SampleIn    = 8'h77;
        SampleValid = 1'b1;
        DataOut     = 8'h04;
        Ready       = 1'b1;
        begin
            exp_t x;
            x.und = 1'b1; x.mat = 1'b1; x.err = 8'd255; x.held = 8'h04;
            exp_q.push_back(x);
        end
        @(negedge Clock);
        SampleValid = 1'b0;
        Ready       = 1'b0;
        acquire(8'h04, 1'b0, 1'b1, 8'd255, 8'h77);

        // Tolerance boundary: diff 2 fails, diff 1 passes.
        acquire(8'h75, 1'b1, 1'b0, 8'd255, 8'h77);
        acquire(8'h78, 1'b1, 1'b1, 8'd255, 8'h77);

        // Closed loop with the bench controller.
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) push(samples[i]);
        acquire(8'h00, 1'b0, 1'b1, 8'd0, samples[0]);
        for (int i = 0; i < 4; i++) begin
            convert(res);
            chk("conv_result", int'(res), int'(samples[i]));
            acquire(res, (i == 3), 1'b1, 8'd0, (i < 3) ? samples[i+1] : samples[3]);
        end

        // Reset mid-conversion with three samples queued.
        push(8'h11); push(8'h22); push(8'h33);
        acquire(8'h00, 1'b0, 1'b0, 8'd1, 8'h11);
        push(8'h44);
        @(negedge Clock);
        compare_at("pre_reset_compare", 8'h00, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_vals("post_reset");
        acquire(8'h00, 1'b1, 1'b1, 8'd0, 8'h00);

        repeat (2) @(negedge Clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
